// File: rtl/mux2_select_arbiter.sv
// mux2_select_arbiter
// Two-requester round-robin arbiter that drives the select input of the
// downstream 2:1 mux. One source owns the mux at a time. The owner keeps the
// select stable while it is active. After HOLD_MAX consecutive cycles, if the
// other source is waiting, the owner is forced to hand over.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req_a     source A request (level, held until served)
//   req_b     source B request (level, held until served)
//   done      current owner releases this cycle (ignored while idle)
//   sel       mux select: 0 = A, 1 = B (registered)
//   gnt_a     A owns the mux (registered)
//   gnt_b     B owns the mux (registered)
//   busy      gnt_a | gnt_b (registered)
//   dbg_state current FSM state: 0 = IDLE, 1 = OWN_A, 2 = OWN_B
//
// Handshake: a requester holds req_x high until it sees gnt_x. The grant lasts
// until one of three things happens: the owner pulses done, the owner drops
// req_x, or the hold limit expires while the other source is requesting. When
// the other source is waiting at release time, the grant passes straight to it
// on the same edge, with no overlap and no gap.
module mux2_select_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       done,
    output logic       sel,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       busy,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    // last: 0 = A was granted last, 1 = B was granted last
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            last_q, last_d;
    logic            sel_q, sel_d;

    logic            mine_req;
    logic            other_req;
    logic            release_now;

    // Requests seen from the current owner's point of view
    always_comb begin
        mine_req  = 1'b0;
        other_req = 1'b0;
        if (state_q == OWN_A) begin
            mine_req  = req_a;
            other_req = req_b;
        end else if (state_q == OWN_B) begin
            mine_req  = req_b;
            other_req = req_a;
        end
    end

    // done and hold expiry landing on the same cycle is still a single release
    assign release_now = done || !mine_req || ((cnt_q == CNT_MAX) && other_req);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sel_d   = sel_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req_a && (!req_b || last_q)) begin
                    state_d = OWN_A;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b0;
                    sel_d   = 1'b0;
                end else if (req_b) begin
                    state_d = OWN_B;
                    cnt_d   = CNT_ONE;
                    last_d  = 1'b1;
                    sel_d   = 1'b1;
                end
            end
            OWN_A, OWN_B: begin
                if (release_now) begin
                    if (other_req) begin
                        // Direct handoff; select flips on the grant edge
                        state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
                        cnt_d   = CNT_ONE;
                        last_d  = (state_q == OWN_A);
                        sel_d   = (state_q == OWN_A);
                    end else begin
                        // Re-granting the same source always costs one idle cycle
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt_a   <= (state_d == OWN_A);
            gnt_b   <= (state_d == OWN_B);
            busy    <= (state_d != IDLE);
        end
    end

    assign sel       = sel_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mux2_select_arbiter.sv
// Testbench for mux2_select_arbiter. Directed scenarios plus a randomized run,
// checked against a behavioural model of owner / hold-time / last-winner.
module tb_mux2_select_arbiter;

  localparam int HOLD_MAX = 4;

  logic       clk;
  logic       rst;
  logic       req_a;
  logic       req_b;
  logic       done;
  logic       sel;
  logic       gnt_a;
  logic       gnt_b;
  logic       busy;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sel, gnt_a, gnt_b, busy}
  logic [3:0] exp_q[$];

  // Reference model: owner 0 = none, 1 = A, 2 = B
  int   m_owner = 0;
  int   m_held  = 0;
  int   m_last  = 2;
  logic m_sel   = 1'b0;

  logic prev_sel, prev_gnt_a, prev_gnt_b;

  mux2_select_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .done      (done),
    .sel       (sel),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled on that edge
  task automatic model_step(input logic ra, input logic rb, input logic d, input logic r);
    int pick;
    logic mine, other;
    if (r) begin
      m_owner = 0; m_held = 0; m_last = 2; m_sel = 1'b0;
    end else if (m_owner == 0) begin
      if (ra && rb) pick = (m_last == 1) ? 2 : 1;
      else if (ra)  pick = 1;
      else if (rb)  pick = 2;
      else          pick = 0;
      if (pick != 0) begin
        m_owner = pick; m_held = 1; m_last = pick; m_sel = (pick == 2);
      end
    end else begin
      mine  = (m_owner == 1) ? ra : rb;
      other = (m_owner == 1) ? rb : ra;
      if (d || !mine || (m_held >= HOLD_MAX && other)) begin
        if (other) begin
          m_owner = 3 - m_owner; m_held = 1; m_last = m_owner; m_sel = (m_owner == 2);
        end else begin
          m_owner = 0; m_held = 0;
        end
      end else begin
        m_held++;
      end
    end
    exp_q.push_back({m_sel, m_owner == 1, m_owner == 2, m_owner != 0});
  endtask

  // Driver: apply inputs, clock once, compare outputs #1 after the edge
  task automatic step(input logic ra, input logic rb, input logic d, input logic r);
    logic [3:0] e;
    logic grant_start;
    req_a = ra; req_b = rb; done = d; rst = r;
    prev_sel = sel; prev_gnt_a = gnt_a; prev_gnt_b = gnt_b;
    model_step(ra, rb, d, r);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sel",   32'(sel),   32'(e[3]));
    check("gnt_a", 32'(gnt_a), 32'(e[2]));
    check("gnt_b", 32'(gnt_b), 32'(e[1]));
    check("busy",  32'(busy),  32'(e[0]));
    check("mutex", 32'(gnt_a & gnt_b), 32'd0);
    grant_start = (gnt_a && !prev_gnt_a) || (gnt_b && !prev_gnt_b);
    if (!r && sel !== prev_sel)
      check("sel_on_grant_start", 32'(grant_start), 32'd1);
  endtask

  initial begin
    logic ra, rb;
    req_a = 1'b0; req_b = 1'b0; done = 1'b0; rst = 1'b1;
    @(negedge clk);

    // Both requesting out of reset: A first, then alternate every HOLD_MAX
    step(1, 1, 0, 1);
    step(1, 1, 0, 1);
    check("reset_gnt_a", 32'(gnt_a), 32'd0);
    check("reset_sel",   32'(sel),   32'd0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0);

    // B alone for 10 cycles: never forced off, sel stays 1 in idle
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    check("b_alone_held", 32'(gnt_b), 32'd1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("idle_sel_kept", 32'(sel), 32'd1);

    // A owns, B arrives, done at cnt=2 hands straight to B
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    check("done_handoff_b", 32'(gnt_b), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

    // Reset while B owns at cnt=3, then A wins first
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 1);
    step(1, 1, 0, 0);
    check("after_reset_a", 32'(gnt_a), 32'd1);
    step(1, 1, 0, 0);

    // A alone with done held: grant 1,0,1,0
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0);

    // Randomized run with sticky requests
    ra = 1'b0; rb = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      step(ra, rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
